song_bram_loader: RTL

SONG_BRAM_LOADER -- requirements
Module: song_bram_loader

---
 rtl/song_pkg.sv | 17 +
 rtl/song_bram_loader.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/song_pkg.sv
// song_pkg: shared definitions for the song BRAM loader.
// Holds the loader state encoding and the song length width.
package song_pkg;

    localparam int SONG_LEN_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CHK    = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } song_state_t;

endpackage

// File: rtl/song_bram_loader.sv
// song_bram_loader: receives a length-prefixed byte stream and writes the
// samples into the song BRAM write port.
// Stream format: len_lo, len_hi, len data bytes [, checksum byte].
// Optional feature macro: SONG_LOADER_CHECKSUM_EN adds a trailing checksum
// byte; sum of data bytes plus that byte must be 0 mod 256.
//
// state  | meaning
// IDLE   | waiting for start after reset
// LEN_LO | expecting length low byte
// LEN_HI | expecting length high byte, length is checked here
// DATA   | accepting sample bytes, one BRAM write per byte
// CHK    | expecting checksum byte (checksum build only)
// DONE   | load succeeded, song_len valid
// ERR    | load failed (length too large or bad checksum)
module song_bram_loader
    import song_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 65536
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [7:0]            mem_din,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [SONG_LEN_W-1:0] song_len
);

    song_state_t           state;
    logic [SONG_LEN_W-1:0] len_q;
    logic [SONG_LEN_W-1:0] remain_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [SONG_LEN_W-1:0] len_w;
    logic                  accept;
`ifdef SONG_LOADER_CHECKSUM_EN
    logic [7:0]            sum_q;
`endif

    assign accept = s_valid & s_ready;
    assign len_w  = {s_data, len_q[7:0]};

    // Status and handshake outputs decoded straight from the state.
    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        case (state)
            LEN_LO, LEN_HI, DATA, CHK: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            default: ;
        endcase
        done  = (state == DONE);
        error = (state == ERR);
    end

    // Load sequencer: length capture, remaining-byte down-counter, BRAM write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            len_q    <= '0;
            remain_q <= '0;
            addr_q   <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            song_len <= '0;
`ifdef SONG_LOADER_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state  <= LEN_LO;
                        addr_q <= '0;
`ifdef SONG_LOADER_CHECKSUM_EN
                        sum_q  <= '0;
`endif
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len_q[7:0] <= s_data;
                        state      <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len_q    <= len_w;
                        remain_q <= len_w;
                        if (len_w == '0) begin
                            song_len <= '0;
                            state    <= DONE;
                        end else if (32'(len_w) > DEPTH) begin
                            state <= ERR;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        mem_we   <= 1'b1;
                        mem_addr <= addr_q;
                        mem_din  <= s_data;
                        addr_q   <= addr_q + 1'b1;
                        remain_q <= remain_q - 1'b1;
`ifdef SONG_LOADER_CHECKSUM_EN
                        sum_q    <= sum_q + s_data;
                        if (remain_q == 16'd1) begin
                            state <= CHK;
                        end
`else
                        if (remain_q == 16'd1) begin
                            song_len <= len_q;
                            state    <= DONE;
                        end
`endif
                    end
                end
`ifdef SONG_LOADER_CHECKSUM_EN
                CHK: begin
                    if (accept) begin
                        if (8'(sum_q + s_data) == 8'd0) begin
                            song_len <= len_q;
                            state    <= DONE;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
